control_sequencer: RTL and testbench

//  Multi-cycle control FSM directly upstream of the output-signal decoder. Fetches
//  23-bit instruction words over a req/ack memory handshake, latches them into the

---
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control FSM with program counter
// Defining SINGLE_STEP_EN adds i_step, so that each pulse releases exactly one fetch.
module control_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_run,
`ifdef SINGLE_STEP_EN
   input  logic            i_step,
`endif
   input  logic [22:0]     i_mem_data,
   input  logic            i_mem_ack,
   output logic            o_mem_req,
   output logic [PC_W-1:0] o_pc,
   output logic [22:0]     o_ir,
   output logic [4:0]      o_state,
   output logic [1:0]      o_alu_op,
   output logic            o_instr_done,
   output logic            o_illegal,
   output logic            o_halted
);

   typedef enum logic [3:0] {
      S_FETCH, S_WAIT, S_DECODE, S_LOAD, S_MOV, S_AR_A, S_AR_B, S_AR_WB, S_HALT
   } fsm_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_MOV  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [4:0] ST_IDLE  = 5'b00000;
   localparam logic [4:0] ST_LOAD  = 5'b00001;
   localparam logic [4:0] ST_MOV   = 5'b00010;
   localparam logic [4:0] ST_AR_A  = 5'b00011;
   localparam logic [4:0] ST_AR_B  = 5'b00100;
   localparam logic [4:0] ST_AR_WB = 5'b00101;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   fsm_t            r_fsm;
   logic            r_mem_req;
   logic [PC_W-1:0] r_pc;
   logic [22:0]     r_ir;
   logic [4:0]      r_state;
   logic [1:0]      r_alu_op;
   logic            r_instr_done;
   logic            r_illegal;
   logic            r_halted;

   logic            w_go;
   logic [2:0]      w_ack_op;
   logic            w_ack_illegal;

`ifdef SINGLE_STEP_EN
   assign w_go = i_run & i_step;
`else
   assign w_go = i_run;
`endif

   // NOP and illegal opcodes finish in DECODE, so their pulses are
   // decided from the incoming word at the ack edge.
   assign w_ack_op      = i_mem_data[22:20];
   assign w_ack_illegal = (w_ack_op == 3'b101) || (w_ack_op == 3'b110);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fsm        <= S_FETCH;
         r_mem_req    <= 1'b0;
         r_pc         <= RESET_PC;
         r_ir         <= '0;
         r_state      <= ST_IDLE;
         r_alu_op     <= 2'b00;
         r_instr_done <= 1'b0;
         r_illegal    <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_instr_done <= 1'b0;
         r_illegal    <= 1'b0;
         case (r_fsm)
            S_FETCH: begin
               r_state <= ST_IDLE;
               if (w_go) begin
                  r_mem_req <= 1'b1;
                  r_fsm     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_mem_ack) begin
                  r_ir         <= i_mem_data;
                  r_pc         <= r_pc + PC_ONE;
                  r_mem_req    <= 1'b0;
                  r_instr_done <= (w_ack_op == OP_NOP) || w_ack_illegal;
                  r_illegal    <= w_ack_illegal;
                  r_fsm        <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (r_ir[22:20])
                  OP_LOAD: begin
                     r_state      <= ST_LOAD;
                     r_instr_done <= 1'b1;
                     r_fsm        <= S_LOAD;
                  end
                  OP_MOV: begin
                     r_state      <= ST_MOV;
                     r_instr_done <= 1'b1;
                     r_fsm        <= S_MOV;
                  end
                  OP_ADD, OP_SUB: begin
                     r_state <= ST_AR_A;
                     r_fsm   <= S_AR_A;
                  end
                  OP_HALT: begin
                     r_halted <= 1'b1;
                     r_fsm    <= S_HALT;
                  end
                  default: r_fsm <= S_FETCH;
               endcase
            end
            S_AR_A: begin
               r_state  <= ST_AR_B;
               r_alu_op <= (r_ir[22:20] == OP_SUB) ? 2'b01 : 2'b00;
               r_fsm    <= S_AR_B;
            end
            S_AR_B: begin
               r_state      <= ST_AR_WB;
               r_instr_done <= 1'b1;
               r_fsm        <= S_AR_WB;
            end
            S_LOAD, S_MOV, S_AR_WB: begin
               r_state <= ST_IDLE;
               r_fsm   <= S_FETCH;
            end
            S_HALT: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
            end
            default: r_fsm <= S_FETCH;
         endcase
      end
   end

   assign o_mem_req    = r_mem_req;
   assign o_pc         = r_pc;
   assign o_ir         = r_ir;
   assign o_state      = r_state;
   assign o_alu_op     = r_alu_op;
   assign o_instr_done = r_instr_done;
   assign o_illegal    = r_illegal;
   assign o_halted     = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
// The model expands each accepted instruction into its per-cycle output steps.
module tb_control_sequencer;

   localparam logic [7:0] RST_PC = 8'hF0;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_run;
`ifdef SINGLE_STEP_EN
   logic        i_step;
`endif
   logic [22:0] i_mem_data;
   logic        i_mem_ack;
   logic        o_mem_req;
   logic [7:0]  o_pc;
   logic [22:0] o_ir;
   logic [4:0]  o_state;
   logic [1:0]  o_alu_op;
   logic        o_instr_done;
   logic        o_illegal;
   logic        o_halted;

   control_sequencer #(.PC_W(8), .RESET_PC(RST_PC)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run),
`ifdef SINGLE_STEP_EN
      .i_step(i_step),
`endif
      .i_mem_data(i_mem_data), .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req),
      .o_pc(o_pc), .o_ir(o_ir), .o_state(o_state), .o_alu_op(o_alu_op),
      .o_instr_done(o_instr_done), .o_illegal(o_illegal), .o_halted(o_halted)
   );

   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // One entry per cycle from DECODE to the last step of an instruction.
   typedef struct packed {
      logic [4:0] st;
      logic [1:0] alu;
      logic       done;
      logic       ill;
      logic       h;
   } step_t;

   step_t       q[$];
   logic [7:0]  m_pc     = RST_PC;
   logic [22:0] m_ir     = '0;
   logic        m_req    = 1'b0;
   logic        m_halted = 1'b0;

   function automatic step_t mk(input logic [4:0] st, input logic [1:0] alu,
                                input logic done, input logic ill, input logic h);
      step_t s;
      s.st = st; s.alu = alu; s.done = done; s.ill = ill; s.h = h;
      return s;
   endfunction

   task automatic push_instr(input logic [2:0] op);
      q.push_back(mk(5'd0, 2'd0, op == 3'd0 || op == 3'd5 || op == 3'd6,
                     op == 3'd5 || op == 3'd6, 1'b0));
      case (op)
         3'd1: q.push_back(mk(5'd1, 2'd0, 1'b1, 1'b0, 1'b0));
         3'd2: q.push_back(mk(5'd2, 2'd0, 1'b1, 1'b0, 1'b0));
         3'd3, 3'd4: begin
            q.push_back(mk(5'd3, 2'd0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(5'd4, (op == 3'd4) ? 2'd1 : 2'd0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(5'd5, 2'd0, 1'b1, 1'b0, 1'b0));
         end
         3'd7: q.push_back(mk(5'd0, 2'd0, 1'b0, 1'b0, 1'b1));
         default: ;
      endcase
   endtask

   task automatic model_update();
      logic go;
      step_t s;
      go = i_run;
`ifdef SINGLE_STEP_EN
      go = i_run & i_step;
`endif
      if (i_rst) begin
         q.delete();
         m_pc = RST_PC; m_ir = '0; m_req = 1'b0; m_halted = 1'b0;
      end else if (q.size() > 0) begin
         s = q.pop_front();
         if (s.h) m_halted = 1'b1;
      end else if (m_req) begin
         if (i_mem_ack) begin
            m_req = 1'b0;
            m_ir  = i_mem_data;
            m_pc  = m_pc + 8'd1;
            push_instr(i_mem_data[22:20]);
         end
      end else if (!m_halted && go) begin
         m_req = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_update();
      #1;
   endtask

   always @(negedge i_clk) begin
      if (cmp_en) begin
         step_t cur;
         cur = (q.size() > 0) ? q[0] : mk(5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
         chk("pc",         32'(o_pc),         32'(m_pc));
         chk("ir",         32'(o_ir),         32'(m_ir));
         chk("mem_req",    32'(o_mem_req),    32'(m_req));
         chk("state",      32'(o_state),      32'(cur.st));
         chk("instr_done", 32'(o_instr_done), 32'(cur.done));
         chk("illegal",    32'(o_illegal),    32'(cur.ill));
         chk("halted",     32'(o_halted),     32'(m_halted | cur.h));
         if (cur.st == 5'd4) chk("alu_op", 32'(o_alu_op), 32'(cur.alu));
      end
   end

   task automatic fetch(input logic [22:0] d, input int dly);
      int n = 0;
      while (!o_mem_req && n < 50) begin tick(); n++; end
      chk("fetch_req", 32'(o_mem_req), 32'd1);
      repeat (dly) tick();
      i_mem_data = d; i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
   endtask

   initial begin
      int n;
      i_rst = 1'b1; i_run = 1'b0; i_mem_data = '0; i_mem_ack = 1'b0;
`ifdef SINGLE_STEP_EN
      i_step = 1'b1;
`endif
      tick();
      cmp_en = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("rst_pc", 32'(o_pc), 32'h0F0);
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_req", 32'(o_mem_req), 32'd0);

      // ack without a request must be ignored
      i_mem_data = 23'h700000; i_mem_ack = 1'b1;
      tick(); tick();
      i_mem_ack = 1'b0;
      chk("stray_ack_ir", 32'(o_ir), 32'd0);

      i_run = 1'b1;
      tick();
      chk("first_req", 32'(o_mem_req), 32'd1);

      // ADD dst=2 src=3
      fetch(23'h323000, 0);
      chk("add_pc", 32'(o_pc), 32'h0F1);
      chk("add_decode", 32'(o_state), 32'd0);
      tick(); chk("add_a", 32'(o_state), 32'd3);
      tick(); chk("add_b", 32'(o_state), 32'd4); chk("add_alu", 32'(o_alu_op), 32'd0);
      tick(); chk("add_wb", 32'(o_state), 32'd5); chk("add_done", 32'(o_instr_done), 32'd1);

      // LOAD then MOV with delayed ack
      fetch(23'h145000, 3);
      tick(); chk("load_st", 32'(o_state), 32'd1); chk("load_done", 32'(o_instr_done), 32'd1);
      fetch(23'h267000, 3);
      tick(); chk("mov_st", 32'(o_state), 32'd2); chk("mov_done", 32'(o_instr_done), 32'd1);

      // dropping run keeps the outstanding request
      n = 0;
      while (!o_mem_req && n < 20) begin tick(); n++; end
      i_run = 1'b0;
      tick(); tick();
      chk("req_held", 32'(o_mem_req), 32'd1);
      fetch(23'h000000, 0);
      repeat (3) tick();
      chk("idle_no_req", 32'(o_mem_req), 32'd0);
      i_run = 1'b1;

      fetch(23'h500000, 0);
      chk("ill_pulse", 32'(o_illegal), 32'd1);
      chk("ill_done", 32'(o_instr_done), 32'd1);
      tick(); chk("ill_once", 32'(o_illegal), 32'd0);

      fetch(23'h412000, 0);
      tick(); tick();
      chk("sub_st", 32'(o_state), 32'd4); chk("sub_alu", 32'(o_alu_op), 32'd1);

      n = 0;
      while (o_pc != 8'hFF && n < 300) begin fetch(23'h000000, 0); n++; end
      chk("pc_at_ff", 32'(o_pc), 32'h0FF);
      fetch(23'h000000, 0);
      chk("pc_wrap", 32'(o_pc), 32'd0);

      // reset in the middle of an ADD
      fetch(23'h323000, 0);
      tick(); tick();
      chk("pre_rst_b", 32'(o_state), 32'd4);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("rst_b_state", 32'(o_state), 32'd0);
      chk("rst_b_pc", 32'(o_pc), 32'h0F0);

      fetch(23'h700000, 0);
      tick(); chk("halt_set", 32'(o_halted), 32'd1);
      repeat (10) tick();
      chk("halt_no_req", 32'(o_mem_req), 32'd0);
      chk("halt_sticky", 32'(o_halted), 32'd1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("halt_clear", 32'(o_halted), 32'd0);

`ifdef SINGLE_STEP_EN
      i_step = 1'b0;
      repeat (10) tick();
      chk("step_idle", 32'(o_mem_req), 32'd0);
      i_step = 1'b1;
      tick();
      i_step = 1'b0;
      chk("step_req", 32'(o_mem_req), 32'd1);
      fetch(23'h000000, 0);
      repeat (10) tick();
      chk("step_single", 32'(o_mem_req), 32'd0);
`endif

      tick();
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
